// File: rtl/univ_reg.sv
// ---------------------------------------------------------------------------
// univ_reg - parametrised universal register
//
// WIDTH-bit register that, on each rising clk edge with en high, performs
// one of eight operations selected by mode: hold, parallel load, shift
// left/right with serial input, rotate left/right, count up, count down.
// co is a registered one-cycle flag holding the bit shifted/rotated out,
// or the wrap (count up) / borrow (count down) indication.
//
// Ports
//   clk     in   1      clock, rising edge active
//   rstbar  in   1      asynchronous active-low reset (q=RESET_VAL, co=0)
//   en      in   1      operation enable; 0 holds q and co
//   mode    in   3      operation select
//   d       in   WIDTH  parallel load data
//   sin_r   in   1      serial in, enters bit 0 on shift left
//   sin_l   in   1      serial in, enters bit WIDTH-1 on shift right
//   q       out  WIDTH  register contents
//   qbar    out  WIDTH  ~q (combinational)
//   co      out  1      registered carry / serial-out flag
//   zero    out  1      q == 0 (combinational)
// ---------------------------------------------------------------------------
module univ_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rstbar,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             co,
    output logic             zero
);

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_LOAD = 3'b001,
        M_SHL  = 3'b010,
        M_SHR  = 3'b011,
        M_ROL  = 3'b100,
        M_ROR  = 3'b101,
        M_UP   = 3'b110,
        M_DN   = 3'b111
    } mode_e;

    localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_nxt;
    logic             co_nxt;
    // One extra bit on the arithmetic result captures wrap (up) / borrow (down)
    logic [WIDTH:0]   inc_ext;
    logic [WIDTH:0]   dec_ext;

    assign inc_ext = {1'b0, q} + ONE_EXT;
    assign dec_ext = {1'b0, q} - ONE_EXT;

    always_comb begin
        q_nxt  = q;
        co_nxt = co;
        if (en) begin
            co_nxt = 1'b0;
            case (mode_e'(mode))
                M_HOLD: q_nxt = q;
                M_LOAD: q_nxt = d;
                M_SHL: begin
                    q_nxt  = {q[WIDTH-2:0], sin_r};
                    co_nxt = q[WIDTH-1];
                end
                M_SHR: begin
                    q_nxt  = {sin_l, q[WIDTH-1:1]};
                    co_nxt = q[0];
                end
                M_ROL: begin
                    q_nxt  = {q[WIDTH-2:0], q[WIDTH-1]};
                    co_nxt = q[WIDTH-1];
                end
                M_ROR: begin
                    q_nxt  = {q[0], q[WIDTH-1:1]};
                    co_nxt = q[0];
                end
                M_UP: begin
                    q_nxt  = inc_ext[WIDTH-1:0];
                    co_nxt = inc_ext[WIDTH];
                end
                M_DN: begin
                    q_nxt  = dec_ext[WIDTH-1:0];
                    co_nxt = dec_ext[WIDTH];
                end
                default: q_nxt = q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstbar) begin
        if (!rstbar) begin
            q  <= RESET_VAL;
            co <= 1'b0;
        end else begin
            q  <= q_nxt;
            co <= co_nxt;
        end
    end

    assign qbar = ~q;
    assign zero = (q == '0);

endmodule
